cbd_tick_prescaler: RTL
=======================

# cbd_tick_prescaler

Programmable prescaler that generates the single-cycle count-enable pulse driving the CAI input of a cascaded 4-bit down-counter chain. A loadable divide value sets the tick period. The block has run, stop and one-shot control, and exposes busy/done status for the sequencer. It sits directly upstream of the counter chain and shares its clock.

## Interface
- WIDTH, 8: width of divide value and internal count.
- CLK  in  1  rising-edge clock, shared with the downstream counter chain.
- CDN  in  1  asynchronous active-low reset (clear), one clock, async active-low.
- EN  in  1  count enable; 0 pauses the prescaler in RUN with all state held.
- LD  in  1  load strobe; captures DIV into the reload register.
- DIV  in  WIDTH  divide value; tick period = DIV+1 enabled cycles.
- START  in  1  start/restart pulse.
- STOP  in  1  stop pulse; returns to IDLE.
- ONESHOT  in  1  sampled at START; 1 = emit a single tick, then go to DONE.
- TICK  out  1  registered one-cycle pulse, connects to CAI of the first counter stage.
- BUSY  out  1  high in RUN.
- DONE  out  1  high in DONE (one-shot finished).
- CNT  out  WIDTH  current internal count.

## Operation
- Registers: reload[WIDTH], cnt[WIDTH], state (IDLE, RUN, DONE), os_mode, TICK.
- Control priority within a cycle: STOP > START > count. LD is independent of that priority and can coincide with any of them.
- LD, any state: reload <= DIV.
  - In IDLE or DONE, also cnt <= DIV.
  - In RUN, cnt is untouched; the new value applies at the next reload.
- IDLE:
  - START -> RUN; cnt <= (LD ? DIV : reload); os_mode <= ONESHOT.
  - Otherwise hold.
- RUN with STOP -> IDLE; cnt held, TICK <= 0.
- RUN with START (no STOP): restart; cnt <= (LD ? DIV : reload); os_mode <= ONESHOT; TICK <= 0.
- RUN with EN=0: hold everything; TICK <= 0.
- RUN with EN=1 and cnt != 0: cnt <= cnt-1; TICK <= 0.
- RUN with EN=1 and cnt == 0:
  - TICK <= 1.
  - cnt <= (LD ? DIV : reload).
  - If os_mode, state -> DONE.
- DONE:
  - START -> RUN, same loading as from IDLE.
  - STOP -> IDLE.
  - Otherwise hold; TICK = 0.
- BUSY = (state == RUN). DONE = (state == DONE). Both are decoded from registered state.
- Arithmetic is unsigned. cnt never wraps, because it reloads at 0.
- DIV = 0 gives TICK every enabled cycle (continuous CAI).
- DIV = 2^WIDTH-1 gives a period of 2^WIDTH.

## Timing
- Reset (CDN low, asynchronous, immediate):
  - state = IDLE; reload = 0; cnt = 0; os_mode = 0.
  - TICK = 0; BUSY = 0; DONE = 0; CNT = 0.
- Reset is released synchronously to CLK by the system. The first active edge after release may take START.
- START at edge E: cnt = reload after E. With EN held high, TICK rises at edge E+reload+1 and stays high for exactly one cycle.
- Free-running period: TICK high once every reload+1 enabled cycles. EN low cycles stretch the period one-for-one.
- TICK is never high two consecutive cycles unless reload = 0 and EN stays high.
- One-shot: DONE and TICK rise on the same edge. BUSY falls on that edge.
- Reset mid-RUN: TICK drops immediately; no pending tick survives.
- STOP in the same cycle as a terminal count (cnt = 0, EN = 1): STOP wins, no TICK.

## Test plan
- Reset, LD DIV=3, START, EN=1 -> TICK at edges 4, 8, 12 after START; CNT sequence 3,2,1,0,3.
- DIV=0, START, EN=1 for 5 cycles -> TICK high all 5 cycles; BUSY=1.
- DIV=5, ONESHOT=1, START -> single TICK at edge 6; DONE=1 and BUSY=0 from that edge; no further TICK for 20 cycles.
- DIV=4 running, EN toggled 0 for 3 cycles mid-count -> TICK delayed by exactly 3 cycles; CNT frozen during pause.
- RUN with DIV=2, LD DIV=6 mid-count -> current period completes with 2, next period 7 cycles; in the same run, STOP at cnt=0 with EN=1 -> no TICK, state IDLE.
- CDN asserted low while BUSY=1 and TICK=1 -> TICK, BUSY, DONE and CNT go to 0 without a clock; after release, START with DIV unloaded -> TICK every cycle (reload=0).

Source files
------------

// File: rtl/cbd_tick_prescaler.sv
// Programmable tick prescaler that drives CAI of a cascaded down-counter chain.
// The tick period is DIV+1 enabled cycles, with run/stop/one-shot control.
module cbd_tick_prescaler #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             CDN,
  input  logic             EN,
  input  logic             LD,
  input  logic [WIDTH-1:0] DIV,
  input  logic             START,
  input  logic             STOP,
  input  logic             ONESHOT,
  output logic             TICK,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] CNT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] r_cnt;
  logic             r_os;
  logic             r_tick;
  logic [WIDTH-1:0] w_load_val;

  // A load strobe coinciding with a reload point takes effect immediately.
  assign w_load_val = LD ? DIV : r_reload;

  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      r_state  <= ST_IDLE;
      r_reload <= '0;
      r_cnt    <= '0;
      r_os     <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (LD) r_reload <= DIV;
      case (r_state)
        ST_RUN: begin
          if (STOP) begin
            r_state <= ST_IDLE;
          end else if (START) begin
            r_cnt <= w_load_val;
            r_os  <= ONESHOT;
          end else if (EN) begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - ONE;
            end else begin
              r_tick <= 1'b1;
              r_cnt  <= w_load_val;
              if (r_os) r_state <= ST_DONE;
            end
          end
        end
        default: begin
          if (LD) r_cnt <= DIV;
          if (STOP) begin
            r_state <= ST_IDLE;
          end else if (START) begin
            r_state <= ST_RUN;
            r_cnt   <= w_load_val;
            r_os    <= ONESHOT;
          end
        end
      endcase
    end
  end

  assign TICK = r_tick;
  assign BUSY = (r_state == ST_RUN);
  assign DONE = (r_state == ST_DONE);
  assign CNT  = r_cnt;

endmodule
